// File: rtl/expr_eval_pkg.sv
// Shared definitions for the character-stream blocks: ASCII constants, FSM
// state encoding, character classes and accumulator opcodes.
package expr_eval_pkg;

  localparam logic [7:0] CH_0   = 8'd48;
  localparam logic [7:0] CH_9   = 8'd57;
  localparam logic [7:0] CH_ADD = 8'd43;
  localparam logic [7:0] CH_MUL = 8'd42;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_OP   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CL_DIGIT = 2'd0,
    CL_ADD   = 2'd1,
    CL_MUL   = 2'd2,
    CL_OTHER = 2'd3
  } cls_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_DIGIT = 2'd1,
    OP_ADD   = 2'd2,
    OP_MUL   = 2'd3
  } op_t;

  // '*' only counts as an operator when multiplication is enabled.
  function automatic cls_t classify(input logic [7:0] ch, input logic mul_en);
    if (ch >= CH_0 && ch <= CH_9) return CL_DIGIT;
    if (ch == CH_ADD) return CL_ADD;
    if (ch == CH_MUL && mul_en) return CL_MUL;
    return CL_OTHER;
  endfunction

endpackage

// File: rtl/expr_eval_if.sv
// Character-in / result-out bundle for expr_eval, with the FSM state exposed
// for observation.
interface expr_eval_if #(parameter int W = 16);
  import expr_eval_pkg::*;

  // in is consumed on every rising edge where in_valid=1; there is no ready,
  // the evaluator accepts one character per cycle unconditionally.
  logic [7:0]   in;
  logic         in_valid;
  logic         out;
  logic         err;
  logic [W-1:0] value;
  state_t       state;

  modport master (output in, in_valid, input out, err, value, state);
  modport slave  (input in, in_valid, output out, err, value, state);
endinterface

// File: rtl/expr_eval_acc.sv
// Sum-of-products accumulator: sum holds finished '+' terms, term the running
// product, num the operand being typed. All arithmetic wraps modulo 2^W.
module expr_eval_acc
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  op_t          op,
  input  logic [3:0]   digit,
  output logic [W-1:0] value
);

  logic [W-1:0] sum;
  logic [W-1:0] term;
  logic [W-1:0] num;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum  <= '0;
      term <= W'(1);
      num  <= '0;
    end else begin
      case (op)
        OP_DIGIT: num <= W'(num * W'(10)) + W'(digit);
        OP_ADD: begin
          sum  <= sum + W'(term * num);
          term <= W'(1);
          num  <= '0;
        end
        OP_MUL: begin
          term <= W'(term * num);
          num  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign value = sum + W'(term * num);

endmodule

// File: rtl/expr_eval.sv
// Streaming recogniser/evaluator for NUM (OP NUM)* with '*' binding tighter
// than '+'. The FSM and digit counter live here; arithmetic is in expr_eval_acc.
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4,
  parameter int MUL_EN     = 1
) (
  input  logic       clk,
  input  logic       clr,
  expr_eval_if.slave bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t       state;
  logic [CW-1:0] digit_cnt;
  cls_t         cls;
  op_t          op;
  logic [3:0]   digit;
  logic [W-1:0] acc_value;
  logic         is_num;

  assign cls   = classify(bus.in, MUL_EN != 0);
  assign digit = 4'(bus.in - CH_0);

  // op is OP_NONE for idle cycles and for any character that lands in S_ERR,
  // so the accumulator freezes exactly when the FSM errors out.
  always_comb begin
    op = OP_NONE;
    if (bus.in_valid) begin
      case (state)
        S_IDLE, S_OP: if (cls == CL_DIGIT) op = OP_DIGIT;
        S_NUM: begin
          case (cls)
            CL_DIGIT: if (digit_cnt < CW'(MAX_DIGITS)) op = OP_DIGIT;
            CL_ADD:   op = OP_ADD;
            CL_MUL:   op = OP_MUL;
            default:  op = OP_NONE;
          endcase
        end
        default: op = OP_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      digit_cnt <= '0;
    end else if (bus.in_valid) begin
      case (op)
        OP_DIGIT: begin
          state     <= S_NUM;
          digit_cnt <= digit_cnt + CW'(1);
        end
        OP_ADD, OP_MUL: begin
          state     <= S_OP;
          digit_cnt <= '0;
        end
        default: state <= S_ERR;
      endcase
    end
  end

  expr_eval_acc #(.W(W)) u_acc (
    .clk   (clk),
    .clr   (clr),
    .op    (op),
    .digit (digit),
    .value (acc_value)
  );

  assign is_num    = (state == S_NUM);
  assign bus.out   = is_num;
  assign bus.err   = (state == S_ERR);
  assign bus.value = is_num ? acc_value : '0;
  assign bus.state = state;

endmodule

// File: tb/tb_expr_eval.sv
// Drives two expr_eval instances (default parameters, and W=8/MAX_DIGITS=3/
// MUL_EN=0) with the same character stream and checks both against a
// string-parsing reference model.
module tb_expr_eval;
  import expr_eval_pkg::*;

  logic clk;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  string hist = "";

  logic [39:0] exp_q[$];
  logic [39:0] mon_e;

  expr_eval_if #(.W(16)) b0 ();
  expr_eval_if #(.W(8))  b1 ();

  expr_eval #(.W(16), .MAX_DIGITS(4), .MUL_EN(1)) dut0 (
    .clk (clk), .clr (clr), .bus (b0.slave)
  );
  expr_eval #(.W(8), .MAX_DIGITS(3), .MUL_EN(0)) dut1 (
    .clk (clk), .clr (clr), .bus (b1.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Returns {state[1:0], out, err, value[15:0]} for the whole prefix s.
  function automatic logic [19:0] model(input string s, input int w,
                                        input int maxd, input bit mul);
    int         run;
    int         st;
    bit         e;
    bit         o;
    logic [7:0] c;
    longint     mask;
    longint     sum;
    longint     prod;
    logic [1:0] stv;
    run  = 0;
    e    = 0;
    mask = (longint'(1) << w) - 1;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'd48 && c <= 8'd57) begin
        run++;
        if (run > maxd) e = 1;
      end else if (c == 8'd43 || (mul && c == 8'd42)) begin
        if (run == 0) e = 1;
        run = 0;
      end else begin
        e = 1;
      end
      if (e) break;
    end
    o    = !e && (run > 0);
    sum  = 0;
    prod = 1;
    if (o) begin
      st = 0;
      for (int i = 0; i <= s.len(); i++) begin
        if (i < s.len()) c = s[i];
        if (i == s.len() || c == 8'd43 || c == 8'd42) begin
          prod = (prod * s.substr(st, i - 1).atoi()) & mask;
          if (i == s.len() || c == 8'd43) begin
            sum  = (sum + prod) & mask;
            prod = 1;
          end
          st = i + 1;
        end
      end
    end
    if (e) stv = 2'd3;
    else if (o) stv = 2'd1;
    else if (s.len() == 0) stv = 2'd0;
    else stv = 2'd2;
    return {stv, o, e, 16'(sum)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("state0", 32'(b0.state), 32'(mon_e[39:38]));
      check("out0",   32'(b0.out),   32'(mon_e[37]));
      check("err0",   32'(b0.err),   32'(mon_e[36]));
      check("value0", 32'(b0.value), 32'(mon_e[35:20]));
      check("state1", 32'(b1.state), 32'(mon_e[19:18]));
      check("out1",   32'(b1.out),   32'(mon_e[17]));
      check("err1",   32'(b1.err),   32'(mon_e[16]));
      check("value1", 32'(b1.value), 32'(mon_e[15:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] ch, input bit v);
    string t;
    @(negedge clk);
    b0.in = ch; b0.in_valid = v;
    b1.in = ch; b1.in_valid = v;
    @(posedge clk);
    if (v) begin
      t    = " ";
      t[0] = ch;
      hist = {hist, t};
    end
    exp_q.push_back({model(hist, 16, 4, 1'b1), model(hist, 8, 3, 1'b0)});
  endtask

  task automatic run_str(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out0"},   32'(b0.out),   32'd0);
    check({tag, "_err0"},   32'(b0.err),   32'd0);
    check({tag, "_value0"}, 32'(b0.value), 32'd0);
    check({tag, "_state0"}, 32'(b0.state), 32'(S_IDLE));
    check({tag, "_out1"},   32'(b1.out),   32'd0);
    check({tag, "_err1"},   32'(b1.err),   32'd0);
    check({tag, "_value1"}, 32'(b1.value), 32'd0);
  endtask

  // Asserts clr mid-cycle, checks the immediate effect, and holds it across a
  // rising edge with a valid character that must be dropped.
  task automatic do_clr();
    @(negedge clk);
    #2;
    clr = 1'b1;
    b0.in = 8'd53; b0.in_valid = 1'b1;
    b1.in = 8'd53; b1.in_valid = 1'b1;
    #1;
    check_cleared("clr_async");
    @(posedge clk);
    #1;
    check_cleared("clr_edge");
    clr = 1'b0;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    hist = "";
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ch;
    int         len;
    int         r;
    clr = 1'b1;
    b0.in = 8'd0; b0.in_valid = 1'b0;
    b1.in = 8'd0; b1.in_valid = 1'b0;
    #3;
    check_cleared("reset");
    @(negedge clk);
    clr = 1'b0;

    run_str("12+3*4");
    do_clr();
    run_str("2*3+4");
    run_str("*5");
    do_clr();
    run_str("+11");
    do_clr();
    run_str("1234");
    do_clr();
    run_str("0070");
    do_clr();
    run_str("200+100");
    do_clr();
    run_str("16*16");
    do_clr();
    run_str("3*");
    do_clr();
    run_str("5");
    for (int i = 0; i < 3; i++) step(8'd43, 1'b0);
    run_str("9+");
    do_clr();
    run_str("9999*9999+65535");
    do_clr();

    for (int n = 0; n < 60; n++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        if (r < 12)       step(8'(48 + $urandom_range(0, 9)), 1'b1);
        else if (r < 15)  step(8'd43, 1'b1);
        else if (r < 17)  step(8'd42, 1'b1);
        else if (r == 17) step(8'($urandom_range(0, 255)), 1'b1);
        else begin
          ch = 8'($urandom_range(0, 255));
          step(ch, 1'b0);
        end
      end
      if ($urandom_range(0, 3) != 0) do_clr();
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
